mpu_store: RTL

- Reads one matrix out of the matrix register file and streams it to an external memory or sink, one float element per accepted beat, in row-major order.
- Counterpart of the load path: register file --> external sink.
- Sits between the register file store port and the MPU's external memory interface.
- Adds sink backpressure and size validation of the size reported by the register file.

---
 rtl/mpu_store.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mpu_store.sv
// Streams one matrix from the matrix register file to an external sink in row-major
// order, one element per accepted beat, validating the size reported by the register file.
module mpu_store #(
    parameter int unsigned M               = 4,
    parameter int unsigned N               = 4,
    parameter int unsigned MBITS           = 2,
    parameter int unsigned NBITS           = 2,
    parameter int unsigned MATRIX_REG_BITS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       store_req_in,
    input  logic [MATRIX_REG_BITS:0]   mem_store_addr_in,
    input  logic                       mem_store_ready_in,
    output logic [31:0]                mem_store_element_out,
    output logic                       mem_store_valid_out,
    output logic [MBITS:0]             mem_i_store_loc_out,
    output logic [NBITS:0]             mem_j_store_loc_out,
    output logic [MBITS:0]             mem_m_store_size_out,
    output logic [NBITS:0]             mem_n_store_size_out,
    output logic                       mem_store_done_out,
    output logic                       mem_store_error_out,
    input  logic                       reg_store_ready_in,
    input  logic [MBITS:0]             reg_m_store_size_in,
    input  logic [NBITS:0]             reg_n_store_size_in,
    input  logic [31:0]                reg_store_element_in,
    output logic                       reg_store_req_out,
    output logic [MATRIX_REG_BITS:0]   reg_store_addr_out,
    output logic [MBITS:0]             reg_i_store_loc_out,
    output logic [NBITS:0]             reg_j_store_loc_out
);

    localparam int unsigned MW = MBITS + 1;
    localparam int unsigned NW = NBITS + 1;
    localparam int unsigned AW = MATRIX_REG_BITS + 1;

    localparam logic [MW-1:0] LP_M_MAX = MW'(M);
    localparam logic [NW-1:0] LP_N_MAX = NW'(N);

    typedef enum logic [1:0] {
        STORE_IDLE,
        STORE_REQUEST,
        STORE_MATRIX,
        STORE_DONE
    } state_t;

    state_t          r_state;
    logic [MW-1:0]   r_row;
    logic [NW-1:0]   r_col;
    logic [MW-1:0]   r_m;
    logic [NW-1:0]   r_n;
    logic [AW-1:0]   r_addr;
    logic            r_valid;
    logic            r_req;
    logic            r_done;
    logic            r_error;

    logic            w_accept;
    logic            w_last_col;
    logic            w_last_row;
    logic            w_size_err;

    assign w_accept   = r_valid & mem_store_ready_in;
    assign w_last_col = (r_col == (r_n - NW'(1)));
    assign w_last_row = (r_row == (r_m - MW'(1)));
    assign w_size_err = (reg_m_store_size_in == '0) || (reg_n_store_size_in == '0) ||
                        (reg_m_store_size_in > LP_M_MAX) || (reg_n_store_size_in > LP_N_MAX);

    // Control FSM; done/error are single-cycle pulses, req/valid follow the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STORE_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_m     <= '0;
            r_n     <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                STORE_IDLE: begin
                    if (store_req_in) begin
                        r_addr  <= mem_store_addr_in;
                        r_req   <= 1'b1;
                        r_state <= STORE_REQUEST;
                    end
                end
                STORE_REQUEST: begin
                    if (reg_store_ready_in) begin
                        r_m <= reg_m_store_size_in;
                        r_n <= reg_n_store_size_in;
                        if (w_size_err) begin
                            r_error <= 1'b1;
                            r_req   <= 1'b0;
                            r_state <= STORE_IDLE;
                        end else begin
                            r_row   <= '0;
                            r_col   <= '0;
                            r_valid <= 1'b1;
                            r_state <= STORE_MATRIX;
                        end
                    end
                end
                STORE_MATRIX: begin
                    if (w_accept) begin
                        if (w_last_col && w_last_row) begin
                            r_valid <= 1'b0;
                            r_req   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= STORE_DONE;
                        end else if (w_last_col) begin
                            r_row <= r_row + MW'(1);
                            r_col <= '0;
                        end else begin
                            r_col <= r_col + NW'(1);
                        end
                    end
                end
                STORE_DONE: begin
                    r_state <= STORE_IDLE;
                end
                default: begin
                    r_state <= STORE_IDLE;
                end
            endcase
        end
    end

    // Element is a combinational pass-through of the register file read, zero when idle.
    assign mem_store_element_out = r_valid ? reg_store_element_in : 32'd0;
    assign mem_store_valid_out   = r_valid;
    assign mem_i_store_loc_out   = r_row;
    assign mem_j_store_loc_out   = r_col;
    assign mem_m_store_size_out  = r_m;
    assign mem_n_store_size_out  = r_n;
    assign mem_store_done_out    = r_done;
    assign mem_store_error_out   = r_error;
    assign reg_store_req_out     = r_req;
    assign reg_store_addr_out    = r_addr;
    assign reg_i_store_loc_out   = r_row;
    assign reg_j_store_loc_out   = r_col;

endmodule
